// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one full-subtractor step per clock, LSB first.
// Start with a one-cycle pulse; done pulses when diff/bout/ovf are updated.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg, res_sh_next;
  logic [CW-1:0]    cnt_reg;
  logic             brw_reg, brw_next, d_bit;
  logic             accept, last;

  // One full-subtractor cell acting on the current LSBs and the carried borrow.
  always_comb begin
    d_bit       = a_sh_reg[0] ^ b_sh_reg[0] ^ brw_reg;
    brw_next    = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & brw_reg);
    res_sh_next = res_sh_reg >> 1;
    res_sh_next[WIDTH-1] = d_bit;
  end

  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last   = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      brw_reg    <= 1'b0;
      cnt_reg    <= '0;
      diff       <= '0;
      bout       <= 1'b0;
      ovf        <= 1'b0;
    end else if (accept) begin
      a_sh_reg <= a;
      b_sh_reg <= b;
      brw_reg  <= bin;
      cnt_reg  <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg   <= a_sh_reg >> 1;
      b_sh_reg   <= b_sh_reg >> 1;
      brw_reg    <= brw_next;
      res_sh_reg <= res_sh_next;
      cnt_reg    <= cnt_reg + CW'(1);
      if (last) begin
        diff <= res_sh_next;
        bout <= brw_next;
        // Overflow: borrow into the MSB differs from borrow out of it.
        ovf  <= brw_reg ^ brw_next;
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

endmodule
